// File: rtl/bash_io_pkg.sv
// Shared constants, state encoding and helpers for the bash line-I/O port.
package bash_io_pkg;

  localparam int unsigned MAX_LEN_DEF = 32;
  localparam int unsigned LEN_W       = 6;
  localparam int unsigned CHAR_W      = 8;

  localparam logic [CHAR_W-1:0] CR_CODE     = 8'h0D;
  localparam logic [CHAR_W-1:0] NL_CODE_DEF = 8'h0A;
  localparam logic [CHAR_W-1:0] BS_CODE_DEF = 8'h08;
  localparam logic [CHAR_W-1:0] PRINT_LO    = 8'h20;
  localparam logic [CHAR_W-1:0] PRINT_HI    = 8'h7E;

  typedef enum logic [1:0] {
    ST_EDIT  = 2'd0,
    ST_SEND  = 2'd1,
    ST_PRINT = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  function automatic logic is_printable(input logic [CHAR_W-1:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/bash_line_buf.sv
// Line storage: append at the tail, erase the last character, clear, and
// indexed read that returns 00 at or past the current length.
module bash_line_buf
  import bash_io_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CHAR_W-1:0] wr_data,
  input  logic              erase,
  input  logic              clear,
  input  logic [LEN_W-1:0]  rd_idx,
  output logic [CHAR_W-1:0] rd_data,
  output logic [LEN_W-1:0]  len
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [CHAR_W-1:0] mem_q [MAX_LEN];
  logic [LEN_W-1:0]  len_q, len_d;
  logic              room;

  assign room = (len_q < LEN_W'(MAX_LEN));

  always_comb begin
    len_d = len_q;
    if (clear) begin
      len_d = '0;
    end else if (wr_en && room) begin
      len_d = len_q + LEN_W'(1);
    end else if (erase && (len_q != '0)) begin
      len_d = len_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
    end else begin
      len_q <= len_d;
    end
  end

  // Storage needs no reset: only entries below len are ever visible.
  always_ff @(posedge clk) begin
    if (wr_en && room) begin
      mem_q[AW'(len_q)] <= wr_data;
    end
  end

  assign rd_data = (rd_idx < len_q) ? mem_q[AW'(rd_idx)] : '0;
  assign len     = len_q;

endmodule

// File: rtl/bash_line_port.sv
// Terminal-side end of the bash line-I/O protocol: line editing with echo,
// streaming committed lines to the application, and forwarding its output.
module bash_line_port
  import bash_io_pkg::*;
#(
  parameter int unsigned       MAX_LEN = MAX_LEN_DEF,
  parameter logic [CHAR_W-1:0] NL_CODE = NL_CODE_DEF,
  parameter logic [CHAR_W-1:0] BS_CODE = BS_CODE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kb_valid,
  input  logic [CHAR_W-1:0] kb_ascii,
  output logic              scr_valid,
  output logic [CHAR_W-1:0] scr_char,
  input  logic              scr_ready,
  output logic              out_newASCII_ready,
  output logic [LEN_W-1:0]  out_lineLen,
  output logic [CHAR_W-1:0] lineOut,
  input  logic              lineOut_nextASCII,
  input  logic              in_newASCII_ready,
  input  logic [CHAR_W-1:0] lineIn,
  output logic              lineIn_nextASCII,
  input  logic              in_solved,
  output logic              out_solved
);

  state_e            state_q, state_d;
  logic              scr_valid_q, scr_valid_d;
  logic [CHAR_W-1:0] scr_char_q, scr_char_d;
  logic              enter_q, enter_d;
  logic              nl_q, nl_d;
  logic              nxt_q, nxt_d;
  logic              solved_q, solved_d;
  logic              rdy_q, rdy_d;
  logic [LEN_W-1:0]  line_len_q, line_len_d;
  logic [LEN_W-1:0]  rd_q, rd_d;

  logic              buf_wr, buf_erase, buf_clear;
  logic [LEN_W-1:0]  len;
  logic              scr_acc;

  bash_line_buf #(.MAX_LEN(MAX_LEN)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_wr),
    .wr_data (kb_ascii),
    .erase   (buf_erase),
    .clear   (buf_clear),
    .rd_idx  (rd_q),
    .rd_data (lineOut),
    .len     (len)
  );

  assign scr_acc = scr_valid_q && scr_ready;

  always_comb begin
    state_d     = state_q;
    scr_valid_d = scr_valid_q;
    scr_char_d  = scr_char_q;
    enter_d     = enter_q;
    nl_d        = nl_q;
    nxt_d       = 1'b0;
    solved_d    = 1'b0;
    rd_d        = rd_q;
    buf_wr      = 1'b0;
    buf_erase   = 1'b0;
    buf_clear   = 1'b0;

    unique case (state_q)
      ST_EDIT: begin
        if (scr_valid_q) begin
          // Echo pending: keystrokes are dropped until the screen takes it.
          if (scr_ready) begin
            scr_valid_d = 1'b0;
            if (enter_q) begin
              enter_d = 1'b0;
              state_d = ST_SEND;
            end
          end
        end else if (in_newASCII_ready) begin
          state_d = ST_PRINT;
          nl_d    = 1'b0;
        end else if (kb_valid) begin
          if (is_printable(kb_ascii)) begin
            if (len < LEN_W'(MAX_LEN)) begin
              buf_wr      = 1'b1;
              scr_valid_d = 1'b1;
              scr_char_d  = kb_ascii;
            end
          end else if (kb_ascii == BS_CODE) begin
            if (len != '0) begin
              buf_erase   = 1'b1;
              scr_valid_d = 1'b1;
              scr_char_d  = BS_CODE;
            end
          end else if (kb_ascii == CR_CODE) begin
            scr_valid_d = 1'b1;
            scr_char_d  = NL_CODE;
            enter_d     = 1'b1;
          end
        end
      end

      ST_SEND: begin
        if (lineOut_nextASCII) begin
          if (rd_q < len) begin
            rd_d = rd_q + LEN_W'(1);
          end else begin
            rd_d      = '0;
            buf_clear = 1'b1;
            state_d   = ST_EDIT;
          end
        end
      end

      ST_PRINT: begin
        if (nl_q) begin
          scr_valid_d = 1'b1;
          scr_char_d  = NL_CODE;
          if (scr_acc) begin
            scr_valid_d = 1'b0;
            nl_d        = 1'b0;
            solved_d    = 1'b1;
            state_d     = ST_ACK;
          end
        end else if (scr_acc) begin
          scr_valid_d = 1'b0;
          nxt_d       = 1'b1;
        end else if (nxt_q) begin
          // Settle cycle: the application advances its index on this edge.
          scr_valid_d = 1'b0;
        end else if (in_solved) begin
          nl_d        = 1'b1;
          scr_valid_d = 1'b1;
          scr_char_d  = NL_CODE;
        end else if (!in_newASCII_ready) begin
          scr_valid_d = 1'b0;
          state_d     = ST_EDIT;
        end else if (lineIn != '0) begin
          scr_valid_d = 1'b1;
          scr_char_d  = lineIn;
        end else begin
          scr_valid_d = 1'b0;
        end
      end

      ST_ACK: begin
        state_d = ST_EDIT;
      end

      default: begin
        state_d = ST_EDIT;
      end
    endcase

    rdy_d      = (state_d == ST_SEND);
    line_len_d = (state_d == ST_SEND) ? len : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EDIT;
      scr_valid_q <= 1'b0;
      scr_char_q  <= '0;
      enter_q     <= 1'b0;
      nl_q        <= 1'b0;
      nxt_q       <= 1'b0;
      solved_q    <= 1'b0;
      rdy_q       <= 1'b0;
      line_len_q  <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      scr_valid_q <= scr_valid_d;
      scr_char_q  <= scr_char_d;
      enter_q     <= enter_d;
      nl_q        <= nl_d;
      nxt_q       <= nxt_d;
      solved_q    <= solved_d;
      rdy_q       <= rdy_d;
      line_len_q  <= line_len_d;
      rd_q        <= rd_d;
    end
  end

  assign scr_valid          = scr_valid_q;
  assign scr_char           = scr_char_q;
  assign out_newASCII_ready = rdy_q;
  assign out_lineLen        = line_len_q;
  assign lineIn_nextASCII   = nxt_q;
  assign out_solved         = solved_q;

endmodule
